// File: rtl/vpu_pkg.sv
// Shared VPU types and constants used by the destination collector.
package vpu_pkg;

  localparam int OPERAND_WIDTH  = 32;
  localparam int DST_LANES      = 4;
  localparam int DST_ADDR_WIDTH = 8;
  localparam int DST_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } dst_collect_state_t;

  typedef struct packed {
    logic [DST_ADDR_WIDTH-1:0] addr;
    logic [DST_LEN_WIDTH-1:0]  len;
  } dst_cmd_t;

endpackage

// File: rtl/sal_fifo.sv
// Small synchronous FIFO; read data optionally registered on pop.
// Push on a full FIFO is accepted when a pop happens in the same cycle.
module sal_fifo #(
  parameter int DEPTH_LG2    = 2,
  parameter int DATA_WIDTH   = 32,
  parameter bit RDATA_FF_OUT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LG2-1:0]  wptr;
  logic [DEPTH_LG2-1:0]  rptr;
  logic [DEPTH_LG2:0]    count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LG2+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  generate
    if (RDATA_FF_OUT) begin : g_rdata_ff
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rdata_q <= '0;
        else if (do_pop) rdata_q <= mem[rptr];
      end
      assign rdata = rdata_q;
    end else begin : g_rdata_comb
      assign rdata = mem[rptr];
    end
  endgenerate

endmodule

// File: rtl/vpu_dst_collector.sv
// Collects FU results, packs LANES per word and writes them to the vector register file.
// Optional write-stall counter is built when VPU_DST_COLLECT_STALL_CNT_EN is defined.
import vpu_pkg::*;

module vpu_dst_collector #(
  parameter int LANES          = DST_LANES,
  parameter int FIFO_DEPTH_LG2 = 2,
  parameter int ADDR_WIDTH     = DST_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DST_LEN_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]           cmd_len_i,
  input  logic                           issue_i,
  output logic                           issue_ok_o,
  input  logic [OPERAND_WIDTH-1:0]       result_i,
  input  logic                           done_i,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [ADDR_WIDTH-1:0]          wr_addr_o,
  output logic [LANES*OPERAND_WIDTH-1:0] wr_data_o,
  output logic [LANES-1:0]               wr_strb_o,
  output logic                           instr_done_o,
  output logic [1:0]                     err_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam int LANE_LG2 = $clog2(LANES);
  localparam int CNT_W    = LEN_WIDTH + 1;
  localparam int CRED_W   = FIFO_DEPTH_LG2 + 1;

  // Handshake rule: a write transfers on a clock edge where wr_valid_o && wr_ready_i;
  // wr_valid_o never drops and wr_addr_o/wr_data_o/wr_strb_o never change until then.

  dst_collect_state_t state, state_nxt;

  logic [CNT_W-1:0]               recv_left;
  logic [CNT_W-1:0]               pack_left;
  logic [CNT_W-1:0]               len_ext;
  logic [CRED_W-1:0]              inflight;
  logic [LANE_LG2-1:0]            lane;
  logic                           pop_vld;
  logic [OPERAND_WIDTH-1:0]       fifo_rdata;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           cmd_fire;
  logic                           wr_fire;
  logic                           fill_go;
  logic                           word_done;
  logic                           last_fill;
  logic                           accept_res;
  logic                           err_unexp;
  logic                           err_ovf;
  logic                           cred_inc;
  logic                           cred_dec;
  logic [LANES*OPERAND_WIDTH-1:0] data_nxt;
  logic [LANES-1:0]               strb_nxt;

  assign len_ext    = (cmd_len_i == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, cmd_len_i};
  assign cmd_ready_o = (state == IDLE);
  assign cmd_fire   = cmd_valid_i && cmd_ready_o;
  assign wr_fire    = wr_valid_o && wr_ready_i;

  // A popped result sits in the FIFO read register until it can land in a lane.
  assign fill_go    = pop_vld && (!wr_valid_o || wr_ready_i);
  assign fifo_pop   = !fifo_empty && (!pop_vld || fill_go);
  assign last_fill  = fill_go && (pack_left == CNT_W'(1));
  assign word_done  = fill_go && ((lane == LANE_LG2'(LANES-1)) || (pack_left == CNT_W'(1)));

  assign accept_res = done_i && (state == COLLECT) && (recv_left != '0);
  assign fifo_push  = accept_res && (!fifo_full || fifo_pop);
  assign err_unexp  = done_i && !((state == COLLECT) && (recv_left != '0));
  assign err_ovf    = (accept_res && fifo_full && !fifo_pop) || (issue_i && !issue_ok_o);

  assign issue_ok_o = (inflight < CRED_W'(1 << FIFO_DEPTH_LG2));
  assign cred_inc   = issue_i && issue_ok_o;
  assign cred_dec   = fifo_pop && ((inflight != '0) || cred_inc);

  sal_fifo #(
    .DEPTH_LG2   (FIFO_DEPTH_LG2),
    .DATA_WIDTH  (OPERAND_WIDTH),
    .RDATA_FF_OUT(1'b1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .wdata(result_i),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid_i) state_nxt = COLLECT;
      COLLECT: if (last_fill)   state_nxt = FLUSH;
      FLUSH:   if (wr_fire)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Lane 0 starts a fresh word, so lanes a partial word never reaches stay zero.
  always_comb begin
    data_nxt = (lane == '0) ? '0 : wr_data_o;
    strb_nxt = (lane == '0) ? '0 : wr_strb_o;
    data_nxt[lane*OPERAND_WIDTH +: OPERAND_WIDTH] = fifo_rdata;
    strb_nxt[lane] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recv_left    <= '0;
      pack_left    <= '0;
      inflight     <= '0;
      lane         <= '0;
      pop_vld      <= 1'b0;
      wr_valid_o   <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      wr_strb_o    <= '0;
      instr_done_o <= 1'b0;
      err_o        <= 2'b00;
    end else begin
      if (cmd_fire) begin
        recv_left <= len_ext;
        pack_left <= len_ext;
        lane      <= '0;
        wr_addr_o <= cmd_addr_i;
      end else begin
        if (fifo_push) recv_left <= recv_left - CNT_W'(1);
        if (fill_go)   pack_left <= pack_left - CNT_W'(1);
        if (wr_fire)   wr_addr_o <= wr_addr_o + 1'b1;
        if (fill_go)   lane      <= word_done ? '0 : lane + 1'b1;
      end
      if (fifo_pop)     pop_vld <= 1'b1;
      else if (fill_go) pop_vld <= 1'b0;
      if (fill_go) begin
        wr_data_o <= data_nxt;
        wr_strb_o <= strb_nxt;
      end
      if (word_done)    wr_valid_o <= 1'b1;
      else if (wr_fire) wr_valid_o <= 1'b0;
      case ({cred_inc, cred_dec})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      instr_done_o <= wr_fire && (state == FLUSH);
      err_o        <= err_o | {err_unexp, err_ovf};
    end
  end

`ifdef VPU_DST_COLLECT_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            stall_cnt <= '0;
    else if (cmd_fire)                                     stall_cnt <= '0;
    else if (wr_valid_o && !wr_ready_i && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vpu_dst_collector.sv
// Directed bench for vpu_dst_collector: packing, partial words, credits, stalls, errors, reset.
module tb_vpu_dst_collector;

  localparam int OW = 32;
  localparam int W  = 8 + 4*OW + 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [7:0]    cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic          issue = 1'b0;
  logic          issue_ok;
  logic [OW-1:0] result = '0;
  logic          done = 1'b0;
  logic          wr_valid;
  logic          wr_ready = 1'b0;
  logic [7:0]    wr_addr;
  logic [4*OW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          instr_done;
  logic [1:0]    err;
  logic [31:0]   stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  vpu_dst_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .issue_i     (issue),
    .issue_ok_o  (issue_ok),
    .result_i    (result),
    .done_i      (done),
    .wr_valid_o  (wr_valid),
    .wr_ready_i  (wr_ready),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_strb_o   (wr_strb),
    .instr_done_o(instr_done),
    .err_o       (err),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_done(input logic [OW-1:0] r);
    done   = 1'b1;
    result = r;
    tick();
    done   = 1'b0;
  endtask

  task automatic wait_instr_done(input string tag, input int budget);
    int seen = 0;
    int k = 0;
    while (!seen && k < budget) begin
      tick();
      if (instr_done) seen = 1;
      k++;
    end
    check(tag, W'(seen), W'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, W'({wr_valid, instr_done, err, cmd_ready, issue_ok}), W'(6'b0_0_00_1_1));
    check({tag, "_wr"}, {wr_addr, wr_data, wr_strb}, '0);
    check({tag, "_stall"}, W'(stall_cnt), W'(0));
  endtask

  function automatic logic [W-1:0] word(input logic [7:0] a, input logic [OW-1:0] d3,
                                        input logic [OW-1:0] d2, input logic [OW-1:0] d1,
                                        input logic [OW-1:0] d0, input logic [3:0] s);
    return {a, d3, d2, d1, d0, s};
  endfunction

  // Write-port scoreboard: every accepted word must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL wr_unexpected: observed write %0h expected none", {wr_addr, wr_data, wr_strb});
      end else begin
        check("wr_word", {wr_addr, wr_data, wr_strb}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] exp_stall;
`ifdef VPU_DST_COLLECT_STALL_CNT_EN
    exp_stall = 32'd10;
`else
    exp_stall = 32'd0;
`endif

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: two full words, per-cycle write and done timing
    wr_ready = 1'b1;
    exp_q.push_back(word(8'h10, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000, 4'hF));
    exp_q.push_back(word(8'h11, 32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004, 4'hF));
    send_cmd(8'h10, 8'd8);
    for (int i = 0; i < 12; i++) begin
      done   = (i < 8);
      result = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("t1_wr_valid_c%0d", i), W'(wr_valid), W'(i == 6 || i == 10));
      check($sformatf("t1_instr_done_c%0d", i), W'(instr_done), W'(i == 11));
      check($sformatf("t1_cmd_ready_c%0d", i), W'(cmd_ready), W'(i == 11));
      tick();
    end
    done = 1'b0;
    check("t1_queue", W'(exp_q.size()), W'(0));

    // 2: len=6 -> final partial word with two lanes
    exp_q.push_back(word(8'h20, 32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000, 4'hF));
    exp_q.push_back(word(8'h21, 32'h0, 32'h0, 32'h2000_0005, 32'h2000_0004, 4'h3));
    send_cmd(8'h20, 8'd6);
    for (int i = 0; i < 6; i++) send_done(32'h2000_0000 + 32'(i));
    wait_instr_done("t2_instr_done", 20);
    check("t2_queue", W'(exp_q.size()), W'(0));
    check("t2_cmd_ready", W'(cmd_ready), W'(1));

    // 3: credits and write stalls
    wr_ready = 1'b0;
    exp_q.push_back(word(8'h30, 32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000, 4'hF));
    exp_q.push_back(word(8'h31, 32'h3000_0007, 32'h3000_0006, 32'h3000_0005, 32'h3000_0004, 4'hF));
    send_cmd(8'h30, 8'd8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_issue_ok_%0d", i), W'(issue_ok), W'(1));
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    check("t3_issue_blocked", W'(issue_ok), W'(0));
    tick();
    check("t3_issue_still_blocked", W'(issue_ok), W'(0));
    for (int i = 0; i < 4; i++) send_done(32'h3000_0000 + 32'(i));
    begin
      int n = 0;
      while (!wr_valid && n < 20) begin
        tick();
        n++;
      end
      check("t3_wr_valid_rise", W'(wr_valid), W'(1));
    end
    check("t3_credit_back", W'(issue_ok), W'(1));
    for (int k = 0; k < 10; k++) begin
      issue  = (k < 2);
      done   = (k == 3 || k == 4);
      result = 32'h3000_0004 + 32'(k - 3);
      tick();
    end
    issue = 1'b0;
    done  = 1'b0;
    check("t3_held_addr", W'(wr_addr), W'(8'h30));
    wr_ready = 1'b1;
    tick();
    check("t3_stall_cnt", W'(stall_cnt), W'(exp_stall));
    for (int i = 0; i < 2; i++) begin
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    send_done(32'h3000_0006);
    send_done(32'h3000_0007);
    wait_instr_done("t3_instr_done", 20);
    check("t3_err", W'(err), W'(0));
    check("t3_stall_final", W'(stall_cnt), W'(exp_stall));
    check("t3_queue", W'(exp_q.size()), W'(0));

    // 4: unexpected result in IDLE, then overflow of a full FIFO
    send_done(32'hDEAD_0000);
    tick();
    check("t4_err_unexp", W'(err), W'(2'b10));
    check("t4_no_write", W'(wr_valid), W'(0));
    wr_ready = 1'b0;
    send_cmd(8'h40, 8'd16);
    for (int i = 0; i < 10; i++) send_done(32'h4000_0000 + 32'(i));
    tick();
    tick();
    check("t4_err_ovf", W'(err), W'(2'b11));
    check("t4_word_held", W'(wr_valid), W'(1));
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t4_reset");
    rst_n = 1'b1;
    tick();

    // 5: push into a full FIFO while it pops
    exp_q.push_back(word(8'h50, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000, 4'hF));
    exp_q.push_back(word(8'h51, 32'h5000_0007, 32'h5000_0006, 32'h5000_0005, 32'h5000_0004, 4'hF));
    exp_q.push_back(word(8'h52, 32'h5000_000B, 32'h5000_000A, 32'h5000_0009, 32'h5000_0008, 4'hF));
    exp_q.push_back(word(8'h53, 32'h5000_000F, 32'h5000_000E, 32'h5000_000D, 32'h5000_000C, 4'hF));
    send_cmd(8'h50, 8'd16);
    for (int i = 0; i < 9; i++) send_done(32'h5000_0000 + 32'(i));
    tick();
    tick();
    check("t5_err_before", W'(err), W'(0));
    wr_ready = 1'b1;
    send_done(32'h5000_0009);
    check("t5_err_after", W'(err), W'(0));
    for (int i = 10; i < 16; i++) send_done(32'h5000_0000 + 32'(i));
    wait_instr_done("t5_instr_done", 30);
    check("t5_err_final", W'(err), W'(0));
    check("t5_queue", W'(exp_q.size()), W'(0));

    // 6: reset mid-COLLECT, then a normal instruction
    send_cmd(8'h60, 8'd8);
    for (int i = 0; i < 3; i++) send_done(32'h6000_0000 + 32'(i));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(word(8'h70, 32'h7000_0003, 32'h7000_0002, 32'h7000_0001, 32'h7000_0000, 4'hF));
    send_cmd(8'h70, 8'd4);
    for (int i = 0; i < 4; i++) send_done(32'h7000_0000 + 32'(i));
    wait_instr_done("t6_instr_done", 20);
    check("t6_err", W'(err), W'(0));
    check("t6_queue", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
